// File: rtl/input_port_unit.sv
`default_nettype none
// ============================================================================
// Module   : input_port_unit
// Purpose  : NoC router input port. Flit FIFO, XY route computation on head
//            flits, wormhole route hold and switch arbiter request/pop.
// Revision : 1.0
// ============================================================================
module input_port_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int N_REGISTER = 3,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int CUR_X      = 0,
    parameter int CUR_Y      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_full,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [N_REGISTER-1:0] request,
    input  logic                  grant,
    output logic                  err_drop
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_route  = 2'd1;
    localparam logic [1:0] c_st_active = 2'd2;

    localparam logic [N_REGISTER-1:0] c_req_none = N_REGISTER'(0);
    localparam logic [N_REGISTER-1:0] c_req_l    = N_REGISTER'(1);
    localparam logic [N_REGISTER-1:0] c_req_n    = N_REGISTER'(2);
    localparam logic [N_REGISTER-1:0] c_req_e    = N_REGISTER'(3);
    localparam logic [N_REGISTER-1:0] c_req_s    = N_REGISTER'(4);
    localparam logic [N_REGISTER-1:0] c_req_w    = N_REGISTER'(5);

    localparam logic [2:0]            c_cur_x   = 3'(CUR_X);
    localparam logic [2:0]            c_cur_y   = 3'(CUR_Y);
    localparam logic [ADDR_WIDTH:0]   c_depth   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_cnt_one = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [N_REGISTER-1:0] r_route;
    logic [N_REGISTER-1:0] w_route_calc;
    logic                  r_err_drop;

    logic                  w_not_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_overflow;
    logic                  w_idle_drop;
    logic                  w_route_load;
    logic                  w_route_clear;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_head_is_start;
    logic                  w_head_is_end;
    logic [2:0]            w_dx;
    logic [2:0]            w_dy;

    assign w_not_empty     = (r_count != '0);
    assign in_full         = (r_count == c_depth);
    assign w_head          = r_mem[r_rd_ptr];
    assign out_data        = w_not_empty ? w_head : '0;
    assign w_push          = in_valid && !in_full;
    assign w_overflow      = in_valid && in_full;
    // Type 01/11 opens a packet, type 10/11 closes one.
    assign w_head_is_start = w_head[DATA_WIDTH-2];
    assign w_head_is_end   = w_head[DATA_WIDTH-1];
    assign w_dx            = w_head[5:3];
    assign w_dy            = w_head[2:0];
    assign err_drop        = r_err_drop;

    // Dimension-ordered routing: resolve X first, then Y, else eject locally.
    always_comb begin
        w_route_calc = c_req_l;
        if (w_dx > c_cur_x) begin
            w_route_calc = c_req_e;
        end else if (w_dx < c_cur_x) begin
            w_route_calc = c_req_w;
        end else if (w_dy > c_cur_y) begin
            w_route_calc = c_req_n;
        end else if (w_dy < c_cur_y) begin
            w_route_calc = c_req_s;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_pop         = 1'b0;
        w_idle_drop   = 1'b0;
        w_route_load  = 1'b0;
        w_route_clear = 1'b0;
        request       = c_req_none;
        case (r_state)
            c_st_idle: begin
                if (w_not_empty) begin
                    if (w_head_is_start) begin
                        w_next_state = c_st_route;
                    end else begin
                        w_pop       = 1'b1;
                        w_idle_drop = 1'b1;
                    end
                end
            end
            c_st_route: begin
                w_route_load = 1'b1;
                w_next_state = c_st_active;
            end
            c_st_active: begin
                // An empty FIFO mid-packet is a bubble; the route stays held.
                if (w_not_empty) begin
                    request = r_route;
                    if (grant) begin
                        w_pop = 1'b1;
                        if (w_head_is_end) begin
                            w_route_clear = 1'b1;
                            w_next_state  = c_st_idle;
                        end
                    end
                end
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_state    <= c_st_idle;
            r_route    <= c_req_none;
            r_err_drop <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
            r_state <= w_next_state;
            if (w_route_load) begin
                r_route <= w_route_calc;
            end else if (w_route_clear) begin
                r_route <= c_req_none;
            end
            r_err_drop <= w_overflow || w_idle_drop;
        end
    end

endmodule
`default_nettype wire
